ring_osc_meter: RTL and testbench

Measurement controller for the free-running LUT ring oscillator. It gates the ring's enable, waits for the ring to settle, then counts synchronized ring-tap rising edges over a programmable window of `clk` cycles. The count is presented on a valid/ready result port. It sits between the ring instance (drives its enable, samples its divided tap) and whatever host logic reads oscillator frequency.

---
 rtl/ring_osc_meter.sv | 157 +++++++++++++++
 tb/tb_ring_osc_meter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_osc_meter.sv
// ring_osc_meter: measures the frequency of a free-running ring oscillator.
// The block enables the ring and lets it settle for WARMUP cycles. It then
// counts synchronized rising edges of ring_tap over a gate window of
// gate_cycles clk cycles, and presents the count on a valid/ready port.
// Optional build macro: RING_METER_CONTINUOUS_EN. When it is defined, the
// block re-arms after each result handshake instead of returning to idle.
module ring_osc_meter #(
  parameter int GATE_W  = 16,
  parameter int COUNT_W = 20,
  parameter int WARMUP  = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [GATE_W-1:0]  gate_cycles,
  input  logic               ring_tap,
  output logic               ring_en,
  output logic               busy,
  output logic [COUNT_W-1:0] result,
  output logic               result_valid,
  input  logic               result_ready,
  output logic               overflow
);

  localparam int WARM_W = (WARMUP > 2) ? $clog2(WARMUP) : 2;
  localparam logic [WARM_W-1:0]  WARM_INIT = WARM_W'(WARMUP - 1);
  localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WARMUP = 2'd1,
    S_GATE   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t              state_q;
  logic [GATE_W-1:0]   gate_len_q;
  logic [GATE_W-1:0]   gate_len_d;
  logic [GATE_W-1:0]   gate_cnt_q;
  logic [WARM_W-1:0]   warm_cnt_q;
  logic [COUNT_W-1:0]  edge_cnt_q;
  logic                overflow_q;
  logic                ring_en_q;
  logic                busy_q;
  logic                valid_q;
  logic [2:0]          tap_sync_q;
  logic [2:0]          tap_sync_d;
  logic                tap_rise;

  // Two synchronizer stages, then a third stage holding the previous sample.
  assign tap_sync_d = {tap_sync_q[1:0], ring_tap};
  assign tap_rise   = tap_sync_q[1] & ~tap_sync_q[2];

  // A window length of zero would make no sense, so it is measured as one.
  assign gate_len_d = (gate_cycles == '0) ? GATE_W'(1) : gate_cycles;

  // Tap synchronizer runs in every state so its history is always fresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap_sync_q <= 3'b000;
    end else begin
      tap_sync_q <= tap_sync_d;
    end
  end

  // Measurement FSM, with its counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      gate_len_q <= '0;
      gate_cnt_q <= '0;
      warm_cnt_q <= '0;
      edge_cnt_q <= '0;
      overflow_q <= 1'b0;
      ring_en_q  <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else if (abort) begin
      state_q   <= S_IDLE;
      ring_en_q <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ring_en_q <= 1'b0;
          busy_q    <= 1'b0;
          valid_q   <= 1'b0;
          if (start) begin
            gate_len_q <= gate_len_d;
            warm_cnt_q <= WARM_INIT;
            state_q    <= S_WARMUP;
            ring_en_q  <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        S_WARMUP: begin
          // Edges seen while the ring settles are discarded.
          edge_cnt_q <= '0;
          if (warm_cnt_q == '0) begin
            overflow_q <= 1'b0;
            gate_cnt_q <= gate_len_q - GATE_W'(1);
            state_q    <= S_GATE;
          end else begin
            warm_cnt_q <= warm_cnt_q - WARM_W'(1);
          end
        end
        S_GATE: begin
          if (tap_rise) begin
            if (edge_cnt_q == COUNT_MAX) begin
              overflow_q <= 1'b1;
            end else begin
              edge_cnt_q <= edge_cnt_q + COUNT_W'(1);
            end
          end
          if (gate_cnt_q == '0) begin
            state_q   <= S_DONE;
            ring_en_q <= 1'b0;
            valid_q   <= 1'b1;
          end else begin
            gate_cnt_q <= gate_cnt_q - GATE_W'(1);
          end
        end
        S_DONE: begin
          if (result_ready) begin
            valid_q <= 1'b0;
`ifdef RING_METER_CONTINUOUS_EN
            // Re-arm with the same window; ring_en was low in DONE, which
            // gives the ring a one-cycle restart.
            warm_cnt_q <= WARM_INIT;
            state_q    <= S_WARMUP;
            ring_en_q  <= 1'b1;
            busy_q     <= 1'b1;
`else
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
`endif
          end
        end
        default: begin
          state_q   <= S_IDLE;
          ring_en_q <= 1'b0;
          busy_q    <= 1'b0;
          valid_q   <= 1'b0;
        end
      endcase
    end
  end

  assign ring_en      = ring_en_q;
  assign busy         = busy_q;
  assign result       = edge_cnt_q;
  assign result_valid = valid_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_ring_osc_meter.sv
// Bench for ring_osc_meter: tap is a clk/4 square wave, expected results are
// queued when a measurement is started and checked when result_valid rises.
module tb_ring_osc_meter;

  localparam int GW = 16;
  localparam int CW = 6;
  localparam int W  = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [GW-1:0] gate_cycles = '0;
  logic          ring_tap = 1'b0;
  logic          result_ready = 1'b0;
  logic          ring_en;
  logic          busy;
  logic [CW-1:0] result;
  logic          result_valid;
  logic          overflow;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int   lat;
    int   lo;
    int   hi;
    logic ovf;
  } exp_t;
  exp_t sb[$];

  ring_osc_meter #(.GATE_W(GW), .COUNT_W(CW), .WARMUP(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .gate_cycles  (gate_cycles),
    .ring_tap     (ring_tap),
    .ring_en      (ring_en),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  // clk/4 tap, phase-shifted so it never changes on a clk edge.
  initial begin
    #3;
    forever begin
      #20;
      ring_tap = ~ring_tap;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_result(input int g, input int lo, input int hi, input logic ovf);
    exp_t e;
    int   n;
    n     = (g == 0) ? 1 : g;
    e.lat = W + n;
    e.lo  = lo;
    e.hi  = hi;
    e.ovf = ovf;
    sb.push_back(e);
  endtask

  // Drive start for one edge; returns 1 time unit after that edge.
  task automatic issue(input int g);
    @(negedge clk);
    gate_cycles = GW'(g);
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if (ring_en !== 1'b1 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL start_response: ring_en=%b busy=%b required 1/1", ring_en, busy);
    end
  endtask

  // Wait for result_valid, pop the scoreboard and check against it.
  task automatic wait_result(input string name);
    exp_t e;
    int   cnt;
    cnt = 0;
    while (result_valid !== 1'b1 && cnt < 2000) begin
      tick();
      cnt++;
    end
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_scoreboard: result with empty scoreboard", name);
      return;
    end
    e = sb.pop_front();
    n_cmp++;
    if (cnt != e.lat) begin
      n_err++;
      $display("FAIL %s_latency: valid at start+%0d required start+%0d", name, cnt + 1, e.lat + 1);
    end
    n_cmp++;
    if (int'(result) < e.lo || int'(result) > e.hi) begin
      n_err++;
      $display("FAIL %s_result: got %0d required %0d..%0d", name, result, e.lo, e.hi);
    end
    n_cmp++;
    if (overflow !== e.ovf) begin
      n_err++;
      $display("FAIL %s_overflow: got %b required %b", name, overflow, e.ovf);
    end
    n_cmp++;
    if (ring_en !== 1'b0) begin
      n_err++;
      $display("FAIL %s_ring_en_done: got %b required 0", name, ring_en);
    end
    $display("%s: gate result=%0d overflow=%b latency=start+%0d", name, result, overflow, cnt + 1);
  endtask

  task automatic handshake(input string name);
    @(negedge clk);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    n_cmp++;
    if (result_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s_handshake: valid=%b busy=%b required 0/0", name, result_valid, busy);
    end
  endtask

  task automatic expect_no_valid(input string name, input int cycles);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (result_valid !== 1'b0 || ring_en !== 1'b0) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin
      n_err++;
      $display("FAIL %s_quiet: valid or ring_en asserted, required both 0 for %0d cycles", name, cycles);
    end
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if (ring_en !== 1'b0 || busy !== 1'b0 || result_valid !== 1'b0 ||
        result !== '0 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: en=%b busy=%b valid=%b result=%0d ovf=%b required all 0",
               ring_en, busy, result_valid, result, overflow);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    $display("reset: outputs checked");
  endtask

  task automatic test_basic();
    expect_result(100, 24, 26, 1'b0);
    issue(100);
    wait_result("basic");
    handshake("basic");
  endtask

  task automatic test_gate_zero();
    expect_result(0, 0, 1, 1'b0);
    issue(0);
    wait_result("gate_zero");
    handshake("gate_zero");
  endtask

  task automatic test_saturation();
    expect_result(300, 63, 63, 1'b1);
    issue(300);
    wait_result("saturate");
    handshake("saturate");
    expect_result(20, 4, 6, 1'b0);
    issue(20);
    wait_result("post_saturate");
    handshake("post_saturate");
  endtask

  task automatic test_back_to_back();
    expect_result(12, 2, 4, 1'b0);
    issue(12);
    wait_result("b2b_first");
    handshake("b2b_first");
    // issue() drives start before the very next edge after the handshake.
    expect_result(16, 3, 5, 1'b0);
    issue(16);
    wait_result("b2b_second");
    handshake("b2b_second");
  endtask

  task automatic test_stall();
    logic [CW-1:0] snap;
    bit            bad;
    expect_result(40, 9, 11, 1'b0);
    issue(40);
    wait_result("stall");
    snap = result;
    bad  = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (i == 10) begin
        @(negedge clk);
        gate_cycles = GW'(5);
        start = 1'b1;
      end
      tick();
      start = 1'b0;
      if (result !== snap || ring_en !== 1'b0 || result_valid !== 1'b1 || busy !== 1'b1) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin
      n_err++;
      $display("FAIL stall_hold: result=%0d en=%b valid=%b required %0d/0/1", result, ring_en, result_valid, snap);
    end
    handshake("stall");
    $display("stall: result held at %0d for 50 cycles", snap);
  endtask

  task automatic test_abort();
    issue(100);
    repeat (30) tick();
    @(negedge clk);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_cmp++;
    if (ring_en !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL abort_stop: ring_en=%b busy=%b required 0/0", ring_en, busy);
    end
    expect_no_valid("abort", 150);
    expect_result(30, 6, 9, 1'b0);
    issue(30);
    wait_result("after_abort");
    handshake("after_abort");
  endtask

  task automatic test_reset_mid();
    issue(50);
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (ring_en !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid: ring_en=%b busy=%b required 0/0", ring_en, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    expect_no_valid("reset_mid", 100);
    expect_result(24, 5, 7, 1'b0);
    issue(24);
    wait_result("after_reset");
    handshake("after_reset");
  endtask

  task automatic test_start_abort();
    @(negedge clk);
    gate_cycles = GW'(10);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || ring_en !== 1'b0) begin
      n_err++;
      $display("FAIL start_abort: busy=%b ring_en=%b required 0/0", busy, ring_en);
    end
    expect_no_valid("start_abort", 40);
  endtask

`ifdef RING_METER_CONTINUOUS_EN
  task automatic test_continuous();
    int cnt;
    int gaps;
    result_ready = 1'b1;
    issue(10);
    cnt = 0;
    while (result_valid !== 1'b1 && cnt < 500) begin
      tick();
      cnt++;
    end
    for (int k = 0; k < 3; k++) begin
      cnt  = 0;
      gaps = 0;
      do begin
        tick();
        cnt++;
        if (ring_en === 1'b0) gaps++;
      end while (result_valid !== 1'b1 && cnt < 500);
      n_cmp++;
      if (cnt != W + 11 || gaps != 1) begin
        n_err++;
        $display("FAIL continuous_period: period=%0d gaps=%0d required %0d/1", cnt, gaps, W + 11);
      end
      $display("continuous: period=%0d result=%0d", cnt, result);
    end
    @(negedge clk);
    abort = 1'b1;
    result_ready = 1'b0;
    tick();
    abort = 1'b0;
    expect_no_valid("continuous_abort", 40);
  endtask
`endif

  initial begin
    test_reset();
`ifdef RING_METER_CONTINUOUS_EN
    test_continuous();
`else
    test_basic();
    test_gate_zero();
    test_saturation();
    test_back_to_back();
    test_stall();
    test_abort();
    test_reset_mid();
    test_start_abort();
`endif
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d pending required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
